song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
Auto-play and learn-mode controller for the MiniPiano. It steps through a song ROM of (note, duration) entries and times each note in beats. It drives the same note index (0 = silence, 1..7 = do..xi) and one-hot light bus that the free-play controller produces, so the buzzer and LED paths can be shared. In learn mode it lights the expected key and waits for the player to press the matching key before sounding the note.

Parameters:
BEAT_CYCLES, 25_000_000, clk cycles per beat (0.25 s at 100 MHz); minimum 2
GAP_CYCLES, 2_500_000, silent cycles between consecutive notes; minimum 1
ADDR_W, 5, song ROM address width (song length 2**ADDR_W entries)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level, sampled each clk; begins playback from address 0 when idle
stop  in  1  level; aborts playback
learn_mode  in  1  1 = wait for matching key before each non-rest note; sampled at each LOAD
keys  in  8  one-hot key inputs, bit (i-1) = note i; bit 7 unused
rom_addr  out  ADDR_W  song ROM address
rom_data  in  8  ROM word, valid 1 cycle after rom_addr: [7:4] duration in beats (0 = end of song), [2:0] note index
note  out  8  current note index, 0 = silence
light  out  8  one-hot LED, bit (note-1); 0 when note = 0
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal end of song
err_count  out  8  wrong key presses in learn mode, saturating at 255

Behaviour:
- Reset (async, rst_n = 0): state IDLE; rom_addr, note, light, busy, done, err_count = 0; all counters = 0.
- All outputs are registered and change only on the clk rising edge.
- States: IDLE, FETCH, LOAD, WAIT_KEY, PLAY, GAP, DONE.
- IDLE: start = 1 -> FETCH with rom_addr = 0, err_count cleared.
- FETCH: rom_addr is held for one cycle -> LOAD.
- LOAD: capture rom_data.
  - duration = 0 -> DONE.
  - learn_mode = 1 and note != 0 -> WAIT_KEY.
  - otherwise -> PLAY.
- PLAY: note = captured index; light = one-hot of that index (0 for a rest).
  - Hold for exactly duration x BEAT_CYCLES cycles, then -> GAP.
  - Use a beat counter plus a beat index; no full-product multiplier.
- GAP: note = 0, light = 0 for GAP_CYCLES cycles.
  - Then rom_addr + 1 -> FETCH.
  - If rom_addr = 2**ADDR_W - 1, -> DONE instead; the address does not wrap.
- WAIT_KEY: light = expected one-hot, note = 0.
  - Compare on new presses only: keys goes from 0 to nonzero between consecutive cycles.
  - keys exactly equal to the expected one-hot -> PLAY.
  - Any other nonzero pattern, including multiple keys -> err_count + 1 (saturating), stay in WAIT_KEY.
  - Held keys and keys = 0 are ignored.
- DONE: done = 1 for one cycle, note = light = 0 -> IDLE.
- Latency: the note appears on the 3rd rising edge after the edge that samples start (IDLE->FETCH->LOAD->PLAY).
- stop = 1 in any state -> IDLE next edge; note, light, busy = 0; done is not pulsed; err_count is retained.
- stop and start both high in IDLE: stop wins, stay IDLE.
- start while busy: ignored, no restart.
- rst_n asserted mid-note: immediate silence, all outputs return to their reset values.
- A note index of 0 with nonzero duration is a timed rest: note = 0, light = 0, never waits in learn mode.
- Note index 7 drives light bit 6; light bit 7 is always 0.

Decomposition:
- Shared package piano_pkg:
  - note constants REST = 0, DO = 1 .. XI = 7
  - state enum for the seven states
  - ROM field positions DUR_MSB = 7, DUR_LSB = 4, NOTE_MSB = 2, NOTE_LSB = 0
  - function note_to_light(index) -> one-hot, shared with the free-play controller
- One sub-module, beat_timer:
  - loads a beat count and a cycles-per-beat value
  - raises a one-cycle expire pulse when finished
  - used for both PLAY and GAP (GAP loads 1 beat of GAP_CYCLES)

Test Plan (BEAT_CYCLES = 4, GAP_CYCLES = 2, ADDR_W = 3):
- ROM {dur2 note1, dur1 note3, dur0}; pulse start -> note = 1 / light = 0x01 for 8 cycles starting 3 edges after start; 0 for 2 cycles; note = 3 / light = 0x04 for 4 cycles; done pulses once; busy falls.
- Learn mode, ROM {dur1 note5, dur0}; press keys = 0x01, release, press 0x10 -> err_count = 1; light = 0x10 during wait; note = 5 for 4 cycles after the correct press.
- Learn mode, hold keys = 0x03 for 10 cycles -> err_count increments exactly once; state stays WAIT_KEY.
- Assert stop in mid-PLAY -> next edge note = 0, light = 0, busy = 0, no done pulse; a new start replays from rom_addr = 0.
- All 8 ROM entries nonzero -> after entry 7 plus its gap, done pulses and rom_addr does not wrap to 0 while busy.
- Deassert rst_n asynchronously mid-note -> note, light, err_count = 0 before the next clk edge; start and stop high together in IDLE -> no playback.

Source files
------------

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared MiniPiano note, state and ROM-field definitions
package piano_pkg;

    typedef enum logic [2:0] {REST, DO, RE, MI, FA, SO, LA, XI} note_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT_KEY,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 4;
    localparam int NOTE_MSB = 2;
    localparam int NOTE_LSB = 0;

    // Note i lights bit i-1; a rest lights nothing and bit 7 is never driven.
    function automatic logic [7:0] note_to_light(input logic [2:0] idx);
        logic [7:0] l;
        l = 8'd0;
        if (idx != REST)
            l[idx - 3'd1] = 1'b1;
        return l;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - counts a number of beats of a programmable cycle length
module beat_timer #(
    parameter int CNT_W  = 8,
    parameter int BEAT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BEAT_W-1:0] beats,
    input  logic [CNT_W-1:0]  cycles,
    output logic              expire
);

    logic              active_q;
    logic [BEAT_W-1:0] beat_q;
    logic [CNT_W-1:0]  cyc_q;
    logic [CNT_W-1:0]  cpb_q;

    // Both counters run down to zero; expiry is the last cycle of the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            beat_q   <= '0;
            cyc_q    <= '0;
            cpb_q    <= '0;
        end else if (load) begin
            active_q <= (beats != '0);
            beat_q   <= beats - BEAT_W'(1);
            cyc_q    <= cycles - CNT_W'(1);
            cpb_q    <= cycles;
        end else if (active_q) begin
            if (cyc_q == '0) begin
                if (beat_q == '0) begin
                    active_q <= 1'b0;
                end else begin
                    beat_q <= beat_q - BEAT_W'(1);
                    cyc_q  <= cpb_q - CNT_W'(1);
                end
            end else begin
                cyc_q <= cyc_q - CNT_W'(1);
            end
        end
    end

    assign expire = active_q && (cyc_q == '0) && (beat_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - auto-play / learn-mode song sequencer for the MiniPiano
module song_sequencer
    import piano_pkg::*;
#(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              learn_mode,
    input  logic [7:0]        keys,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        note,
    output logic [7:0]        light,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count
);

    localparam int CNT_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [2:0]        cur_note_q, cur_note_d;
    logic [3:0]        dur_q, dur_d;
    logic [7:0]        keys_q;
    logic [7:0]        note_q, note_d;
    logic [7:0]        light_q, light_d;
    logic [7:0]        err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [3:0]        rom_dur;
    logic [2:0]        rom_note;
    logic              rom_unused;
    logic [7:0]        exp_light;
    logic              new_press;
    logic              key_match;

    logic              tmr_load;
    logic              tmr_expire;
    logic [3:0]        tmr_beats;
    logic [CNT_W-1:0]  tmr_cpb;

    assign rom_dur    = rom_data[DUR_MSB:DUR_LSB];
    assign rom_note   = rom_data[NOTE_MSB:NOTE_LSB];
    assign rom_unused = rom_data[3];
    assign exp_light  = note_to_light(cur_note_q);
    // Only a 0 -> nonzero transition on the key bus counts as a press.
    assign new_press  = (keys_q == 8'd0) && (keys != 8'd0);
    assign key_match  = (keys == exp_light);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (start) state_d = ST_FETCH;
                ST_FETCH:    state_d = ST_LOAD;
                ST_LOAD: begin
                    if (rom_dur == 4'd0)
                        state_d = ST_DONE;
                    else if (learn_mode && (rom_note != REST))
                        state_d = ST_WAIT_KEY;
                    else
                        state_d = ST_PLAY;
                end
                ST_WAIT_KEY: if (new_press && key_match) state_d = ST_PLAY;
                ST_PLAY:     if (tmr_expire) state_d = ST_GAP;
                ST_GAP: begin
                    if (tmr_expire)
                        state_d = (rom_addr_q == {ADDR_W{1'b1}}) ? ST_DONE : ST_FETCH;
                end
                ST_DONE:     state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // The timer is reloaded on entry to PLAY (duration beats) and GAP (one short beat).
    always_comb begin
        tmr_load  = 1'b0;
        tmr_beats = 4'd1;
        tmr_cpb   = CNT_W'(GAP_CYCLES);
        if (state_d == ST_PLAY && state_q != ST_PLAY) begin
            tmr_load  = 1'b1;
            tmr_beats = (state_q == ST_LOAD) ? rom_dur : dur_q;
            tmr_cpb   = CNT_W'(BEAT_CYCLES);
        end else if (state_d == ST_GAP && state_q != ST_GAP) begin
            tmr_load  = 1'b1;
        end
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        cur_note_d = cur_note_q;
        dur_d      = dur_q;
        err_d      = err_q;
        note_d     = 8'd0;
        light_d    = 8'd0;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);

        if (state_q == ST_IDLE && state_d == ST_FETCH) begin
            rom_addr_d = '0;
            err_d      = 8'd0;
        end
        if (state_q == ST_GAP && state_d == ST_FETCH)
            rom_addr_d = rom_addr_q + ADDR_W'(1);
        if (state_q == ST_LOAD) begin
            cur_note_d = rom_note;
            dur_d      = rom_dur;
        end
        if (state_q == ST_WAIT_KEY && state_d == ST_WAIT_KEY && new_press
            && !key_match && err_q != 8'hFF)
            err_d = err_q + 8'd1;

        case (state_d)
            ST_PLAY: begin
                note_d  = {5'd0, cur_note_d};
                light_d = note_to_light(cur_note_d);
            end
            ST_WAIT_KEY: light_d = note_to_light(cur_note_d);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            cur_note_q <= 3'd0;
            dur_q      <= 4'd0;
            keys_q     <= 8'd0;
            note_q     <= 8'd0;
            light_q    <= 8'd0;
            err_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            cur_note_q <= cur_note_d;
            dur_q      <= dur_d;
            keys_q     <= keys;
            note_q     <= note_d;
            light_q    <= light_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    beat_timer #(
        .CNT_W  (CNT_W),
        .BEAT_W (4)
    ) u_beat_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .beats  (tmr_beats),
        .cycles (tmr_cpb),
        .expire (tmr_expire)
    );

    assign rom_addr  = rom_addr_q;
    assign note      = note_q;
    assign light     = light_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - randomized scoreboard bench for song_sequencer
module tb_song_sequencer;

    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          learn_mode = 1'b0;
    logic [7:0]    keys = 8'd0;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data = 8'd0;
    logic [7:0]    note;
    logic [7:0]    light;
    logic          busy;
    logic          done;
    logic [7:0]    err_count;

    logic [7:0]    rom_mem [8];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    song_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .ADDR_W      (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .learn_mode (learn_mode),
        .keys       (keys),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note       (note),
        .light      (light),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count)
    );

    typedef struct {
        logic [16:0] val;
        int          len;
    } seg_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    seg_t          exp_q[$];
    logic [16:0]   tl[$];
    logic [7:0]    script[$];
    int            ws;
    int            exp_err;
    logic [AW-1:0] exp_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle expected {done, note, light} while busy, from the song rules.
    task automatic build_timeline(input bit learn);
        tl.delete();
        ws       = -1;
        exp_err  = 0;
        exp_last = 3'd7;
        for (int a = 0; a < 8; a++) begin
            logic [3:0] d;
            logic [2:0] n;
            logic [7:0] lt;
            d  = rom_mem[a][7:4];
            n  = rom_mem[a][2:0];
            lt = (n == 3'd0) ? 8'h00 : (8'h01 << (n - 3'd1));
            repeat (2) tl.push_back(17'h0);
            if (d == 4'd0) begin
                tl.push_back({1'b1, 16'h0});
                exp_last = a[AW-1:0];
                return;
            end
            if (learn && n != 3'd0) begin
                logic [7:0] prev;
                int         wl;
                prev = 8'd0;
                wl   = 0;
                ws   = tl.size();
                foreach (script[c]) begin
                    if (prev == 8'd0 && script[c] != 8'd0) begin
                        if (script[c] == lt) begin
                            wl = c + 1;
                            break;
                        end else if (exp_err < 255) begin
                            exp_err++;
                        end
                    end
                    prev = script[c];
                end
                repeat (wl) tl.push_back({1'b0, 8'h00, lt});
            end
            repeat (int'(d) * BEAT) tl.push_back({1'b0, 5'd0, n, lt});
            repeat (GAP) tl.push_back(17'h0);
        end
        tl.push_back({1'b1, 16'h0});
    endtask

    task automatic push_segments(input int n);
        logic [16:0] cur;
        int          cnt;
        seg_t        s;
        cnt = 0;
        cur = 17'h0;
        for (int i = 0; i < n; i++) begin
            if (cnt > 0 && tl[i] == cur) begin
                cnt++;
            end else begin
                if (cnt > 0) begin
                    s.val = cur;
                    s.len = cnt;
                    exp_q.push_back(s);
                end
                cur = tl[i];
                cnt = 1;
            end
        end
        if (cnt > 0) begin
            s.val = cur;
            s.len = cnt;
            exp_q.push_back(s);
        end
    endtask

    logic [16:0] m_cur = 17'h0;
    int          m_len = 0;

    task automatic close_seg;
        seg_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL seg_extra: got val 0x%0h len %0d, expected no segment", m_cur, m_len);
        end else begin
            e = exp_q.pop_front();
            check("seg_val", m_cur, e.val);
            check("seg_len", m_len, e.len);
        end
        m_len = 0;
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (m_len > 0 && {done, note, light} === m_cur) begin
                m_len++;
            end else begin
                if (m_len > 0) close_seg();
                m_cur = {done, note, light};
                m_len = 1;
            end
            if (done === 1'b1) check("done_addr", rom_addr, exp_last);
        end else begin
            if (m_len > 0) close_seg();
            if (rst_n === 1'b1) check("done_idle", done, 0);
        end
    end

    // cut_kind: 0 = play to the end, 1 = stop at busy cycle cut_at, 2 = reset in cycle cut_at
    task automatic run(input bit learn, input int cut_kind, input int cut_at, input bit hold_start);
        int n;
        build_timeline(learn);
        n = (cut_kind != 0) ? cut_at : tl.size();
        if (cut_kind == 2) exp_err = 0;
        push_segments(n);
        learn_mode = learn;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < n + 3; i++) begin
            #1;
            start = hold_start && (i < 5);
            if (learn && ws >= 0 && i >= ws)
                keys = (i - ws < script.size()) ? script[i - ws] : script[script.size() - 1];
            else
                keys = 8'd0;
            if (i == 0) check("fetch_addr", rom_addr, 0);
            if (cut_kind == 1 && i == cut_at - 1) stop = 1'b1;
            if (cut_kind == 1 && i == cut_at) begin
                stop = 1'b0;
                check("stop_busy", busy, 0);
                check("stop_note", note, 0);
                check("stop_light", light, 0);
                check("stop_done", done, 0);
            end
            if (cut_kind == 2 && i == cut_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_note", note, 0);
                check("rst_light", light, 0);
                check("rst_err", err_count, 0);
                check("rst_busy", busy, 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end
            @(posedge clk);
        end
        keys  = 8'd0;
        start = 1'b0;
        stop  = 1'b0;
        check("end_idle", busy, 0);
        if (busy !== 1'b0) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        check("err_count", err_count, exp_err);
    endtask

    task automatic clear_rom;
        for (int a = 0; a < 8; a++) rom_mem[a] = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lt;
        logic [2:0] nn;
        logic [3:0] dd;
        int         len;
        int         ch;

        clear_rom();
        script.delete();
        #12;
        check("reset_note", note, 0);
        check("reset_light", light, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err_count, 0);
        check("reset_addr", rom_addr, 0);
        #1 rst_n = 1'b1;

        // Basic song, start held high into playback
        rom_mem[0] = 8'h21;
        rom_mem[1] = 8'h13;
        run(1'b0, 0, 0, 1'b1);

        // Learn: wrong key, release, right key
        clear_rom();
        rom_mem[0] = 8'h15;
        script = '{8'h01, 8'h00, 8'h10};
        run(1'b1, 0, 0, 1'b0);
        check("learn_err1", err_count, 1);

        // Learn: two keys held for 10 cycles count once
        script.delete();
        repeat (10) script.push_back(8'h03);
        script.push_back(8'h00);
        script.push_back(8'h10);
        run(1'b1, 0, 0, 1'b0);
        check("hold_err1", err_count, 1);

        // Stop mid-note, then replay from the top
        clear_rom();
        rom_mem[0] = 8'h21;
        rom_mem[1] = 8'h13;
        run(1'b0, 1, 6, 1'b0);
        run(1'b0, 0, 0, 1'b0);

        // Full ROM without an end marker
        for (int a = 0; a < 8; a++) begin
            nn = 3'($urandom_range(0, 7));
            rom_mem[a] = {4'd1, 1'b0, nn};
        end
        run(1'b0, 0, 0, 1'b0);

        // Empty song
        clear_rom();
        run(1'b0, 0, 0, 1'b0);

        // Async reset mid-note, and during a learn wait after an error
        rom_mem[0] = 8'h21;
        rom_mem[1] = 8'h13;
        run(1'b0, 2, 5, 1'b0);
        clear_rom();
        rom_mem[0] = 8'h15;
        script.delete();
        script.push_back(8'h01);
        repeat (20) script.push_back(8'h00);
        script.push_back(8'h10);
        run(1'b1, 2, 6, 1'b0);

        // start and stop together while idle
        @(posedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ss_busy", busy, 0);
        check("ss_note", note, 0);
        start = 1'b0;
        stop  = 1'b0;

        // Random play-mode songs
        for (int it = 0; it < 12; it++) begin
            clear_rom();
            len = $urandom_range(1, 8);
            for (int a = 0; a < len; a++) begin
                dd = 4'($urandom_range(1, 3));
                nn = 3'($urandom_range(0, 7));
                rom_mem[a] = {dd, 1'b0, nn};
            end
            run(1'b0, 0, 0, 1'b0);
        end

        // Random learn-mode songs with random key scripts
        for (int it = 0; it < 10; it++) begin
            clear_rom();
            nn = 3'($urandom_range(1, 7));
            lt = 8'h01 << (nn - 3'd1);
            if ($urandom_range(0, 1) == 1) begin
                rom_mem[0] = 8'h10;
                rom_mem[1] = {4'd1, 1'b0, nn};
            end else begin
                rom_mem[0] = {4'd1, 1'b0, nn};
            end
            script.delete();
            len = $urandom_range(0, 8);
            for (int k = 0; k < len; k++) begin
                ch = $urandom_range(0, 4);
                case (ch)
                    0:       script.push_back(8'h00);
                    1:       script.push_back(lt);
                    2:       script.push_back(8'h03);
                    3:       script.push_back(8'($urandom_range(0, 255)));
                    default: script.push_back(8'h01 << $urandom_range(0, 7));
                endcase
            end
            script.push_back(8'h00);
            script.push_back(lt);
            run(1'b1, 0, 0, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
